// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer between a UART byte stream and sobel_applier.
//
// Parses a 4-byte header (width LE16, height LE16), range-checks it and presents
// it as cfg_*, forwards exactly width*height pixel bytes to the datapath with a
// zero-latency pass-through, then counts (width-2)*(height-2) output handshakes
// and pulses frame_done. Errors are reported as sticky flags on status.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   s_data/s_valid/s_ready byte stream from uart_rx
//   m_data/m_valid/m_ready pixel stream to sobel_applier
//   o_valid, o_ready       monitored output handshake of sobel_applier
//   cfg_width/cfg_height   latched frame dimensions, cfg_valid while in use
//   flush                  one-cycle pulse clearing datapath line buffers
//   busy                   high whenever not idle
//   frame_done             one-cycle pulse at frame completion
//   status                 sticky {overflow, timeout, dim error}
//
// Optional feature: define SOBEL_FRAME_CTRL_TIMEOUT_EN to enable the idle
// timeout (status[1]). Without it a stalled frame waits until rst.
module sobel_frame_ctrl #(
  parameter int unsigned MAX_WIDTH      = 640,
  parameter int unsigned MAX_HEIGHT     = 480,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        o_valid,
  input  logic        o_ready,
  output logic [15:0] cfg_width,
  output logic [15:0] cfg_height,
  output logic        cfg_valid,
  output logic        flush,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  status
);

  localparam int unsigned PixW = $clog2(MAX_WIDTH * MAX_HEIGHT + 1);

  typedef enum logic [2:0] {
    StIdle, StHdr, StCheck, StStream, StDrain, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     height_q, height_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [PixW-1:0] pix_rem_q, pix_rem_d;
  logic [PixW-1:0] out_rem_q, out_rem_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic [2:0]      status_q, status_d;

  logic out_hs;
  logic dims_ok;

  assign out_hs  = o_valid & o_ready;
  assign dims_ok = (width_q >= 16'd3) && (width_q <= 16'(MAX_WIDTH)) &&
                   (height_q >= 16'd3) && (height_q <= 16'(MAX_HEIGHT));

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IdleW-1:0] idle_q, idle_d;
  logic             activity;
  // An accepted byte or an output handshake both count as forward progress.
  assign activity = (s_valid & s_ready) | out_hs;
`endif

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    hdr_cnt_d   = hdr_cnt_q;
    pix_rem_d   = pix_rem_q;
    out_rem_d   = out_rem_q;
    cfg_valid_d = cfg_valid_q;
    status_d    = status_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = 8'd0;
    flush       = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        if (s_valid) begin
          width_d[7:0] = s_data;
          status_d     = 3'b000;
          hdr_cnt_d    = 2'd1;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        s_ready = 1'b1;
        if (s_valid) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd1:    width_d[15:8] = s_data;
            2'd2:    height_d[7:0] = s_data;
            default: begin
              height_d[15:8] = s_data;
              state_d        = StCheck;
            end
          endcase
        end
      end
      StCheck: begin
        if (s_valid) status_d[2] = 1'b1;
        if (dims_ok) begin
          cfg_valid_d = 1'b1;
          flush       = 1'b1;
          // Dimensions are range-checked above, so the truncation and the -2 are safe.
          pix_rem_d   = PixW'(width_q) * PixW'(height_q);
          out_rem_d   = PixW'(width_q - 16'd2) * PixW'(height_q - 16'd2);
          state_d     = StStream;
        end else begin
          status_d[0] = 1'b1;
          state_d     = StErr;
        end
      end
      StStream: begin
        s_ready = m_ready;
        m_data  = s_data;
        m_valid = s_valid & m_ready;
        if (s_valid && m_ready) begin
          if (pix_rem_q != '0) pix_rem_d = pix_rem_q - 1'b1;
          if (pix_rem_q <= PixW'(1)) state_d = StDrain;
        end
        if (s_valid && !m_ready) status_d[2] = 1'b1;
        // The datapath starts emitting before the last input byte arrives.
        if (out_hs && out_rem_q != '0) out_rem_d = out_rem_q - 1'b1;
      end
      StDrain: begin
        if (s_valid) status_d[2] = 1'b1;
        if (out_hs && out_rem_q != '0) out_rem_d = out_rem_q - 1'b1;
        if (out_rem_d == '0) state_d = StDone;
      end
      StDone: begin
        if (s_valid) status_d[2] = 1'b1;
        frame_done  = 1'b1;
        cfg_valid_d = 1'b0;
        state_d     = StIdle;
      end
      StErr: begin
        if (s_valid) status_d[2] = 1'b1;
        flush       = 1'b1;
        cfg_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
    idle_d = '0;
    if ((state_q == StHdr || state_q == StStream || state_q == StDrain) && !activity) begin
      idle_d = idle_q + 1'b1;
      // Completion takes priority over an expiring idle counter.
      if (idle_d >= IdleW'(TIMEOUT_CYCLES) && state_d != StDone) begin
        status_d[1] = 1'b1;
        state_d     = StErr;
      end
    end
`endif

    // Hold the combinational outputs quiet while reset is asserted; sobel_applier is
    // reset at the same time, so no flush is needed.
    if (rst) begin
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = 8'd0;
      flush      = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      width_q     <= '0;
      height_q    <= '0;
      hdr_cnt_q   <= '0;
      pix_rem_q   <= '0;
      out_rem_q   <= '0;
      cfg_valid_q <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pix_rem_q   <= pix_rem_d;
      out_rem_q   <= out_rem_d;
      cfg_valid_q <= cfg_valid_d;
      status_q    <= status_d;
    end
  end

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  assign cfg_width  = width_q;
  assign cfg_height = height_q;
  assign cfg_valid  = cfg_valid_q;
  assign busy       = (state_q != StIdle);
  assign status     = status_q;

endmodule
